// File: rtl/mips_ctrl_pkg.sv
// Shared opcodes, state codes and datapath-select encodings for the multicycle MIPS controller.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11
  } state_e;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/ctrl_wait_timer.sv
// Counts consecutive not-ready cycles while a memory access is pending and flags expiry.
module ctrl_wait_timer #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic busy,
  input  logic ready,
  output logic expire
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  assign expire = busy & ~ready & (cnt_q == TO_W'(TIMEOUT - 1));

  // Expiry also clears so a FETCH->FETCH retry starts a fresh window.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!busy || ready || expire) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath with memory wait timeout.
// Build option: define MULTICYCLE_ADDI_EN to add the ADDI_EX/ADDI_WB path for op 001000.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemToReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state
);

  state_e state_q, state_d;
  ctrl_t  ctl, ctl_g;
  logic   busy, expire, ill;

  assign busy = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

  ctrl_wait_timer #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .busy   (busy),
    .ready  (mem_ready),
    .expire (expire)
  );

  always_comb begin
    state_d = S_FETCH;
    ill     = 1'b0;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MULTICYCLE_ADDI_EN
          OP_ADDI:      state_d = S_ADDI_EX;
`endif
          default: begin
            ill     = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      state_d = S_MEMRD;
        else if (op == OP_SW) state_d = S_MEMWR;
      end
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : (expire ? S_FETCH : S_MEMRD);
      S_MEMWR:  state_d = (mem_ready || expire) ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_RWB;
`ifdef MULTICYCLE_ADDI_EN
      S_ADDI_EX: state_d = S_ADDI_WB;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  // FETCH strobes IR/PC only in the completing cycle, so a timed-out fetch retries the same PC.
  always_comb begin
    ctl = '0;
    case (state_q)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = SRCB_4;
        ctl.ir_write  = mem_ready;
        ctl.pc_write  = mem_ready;
      end
      S_DECODE: ctl.alu_src_b = SRCB_IMMSH;
      S_MEMADR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctl.mem_write = 1'b1;
        ctl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_op        = ALUOP_SUB;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctl.pc_write  = 1'b1;
        ctl.pc_source = PCSRC_JUMP;
      end
`ifdef MULTICYCLE_ADDI_EN
      S_ADDI_EX: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
      end
      S_ADDI_WB: ctl.reg_write = 1'b1;
`endif
      default: ctl = '0;
    endcase
  end

  // Gate with rst_n so strobes drop the instant reset asserts, not at the next edge.
  assign ctl_g       = rst_n ? ctl : '0;
  assign PCWrite     = ctl_g.pc_write;
  assign PCWriteCond = ctl_g.pc_write_cond;
  assign IorD        = ctl_g.iord;
  assign MemRead     = ctl_g.mem_read;
  assign MemWrite    = ctl_g.mem_write;
  assign IRWrite     = ctl_g.ir_write;
  assign MemToReg    = ctl_g.mem_to_reg;
  assign RegDst      = ctl_g.reg_dst;
  assign RegWrite    = ctl_g.reg_write;
  assign ALUSrcA     = ctl_g.alu_src_a;
  assign ALUSrcB     = ctl_g.alu_src_b;
  assign ALUOp       = ctl_g.alu_op;
  assign PCSource    = ctl_g.pc_source;
  assign illegal_op  = rst_n & ill;
  assign mem_err     = rst_n & expire;
  assign state       = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: expected output vectors queued per driven cycle.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemToReg, RegDst, RegWrite, ALUSrcA, illegal_op, mem_err;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;

  int errs   = 0;
  int checks = 0;

  logic [21:0] exp_q[$];
  string       tag_q[$];
  logic [21:0] obs;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BQ = 6'b000100, JJ = 6'b000010, AD = 6'b001000, BAD = 6'b111111;

  multicycle_ctrl #(.TIMEOUT(16), .TO_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .illegal_op(illegal_op), .mem_err(mem_err), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
                RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op, mem_err};

  task automatic chk(input string tag, input logic [21:0] act, input logic [21:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  // Expected output vector for a state, straight from the per-state output table.
  function automatic logic [21:0] ev(input int st, input bit rdy, input bit ill = 1'b0,
                                     input bit merr = 1'b0);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, aluop, pcsrc;
    logic [3:0] s4;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca} = '0;
    srcb = 2'b00; aluop = 2'b00; pcsrc = 2'b00;
    s4 = st[3:0];
    case (st)
      0:  begin mrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
      1:  srcb = 2'b11;
      2:  begin srca = 1; srcb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin srca = 1; aluop = 2'b10; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin srca = 1; aluop = 2'b01; pcwc = 1; pcsrc = 2'b01; end
      9:  begin pcw = 1; pcsrc = 2'b10; end
      10: begin srca = 1; srcb = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    return {s4, pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aluop, pcsrc,
            ill, merr};
  endfunction

  // Drive one cycle's inputs just after the edge and queue what the DUT must show.
  task automatic cyc(input logic [5:0] o, input logic r, input logic [21:0] e, input string tag);
    op        = o;
    mem_ready = r;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) chk(tag_q.pop_front(), obs, exp_q.pop_front());
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; op = LW; mem_ready = 1'b1;
    #12 chk("reset_outs", obs, 22'd0);
    @(posedge clk); #1;
    chk("reset_hold", obs, 22'd0);
    rst_n = 1'b1;

    // LW with ready memory: 0,1,2,3,4
    cyc(LW, 1, ev(0, 1), "lw_f");  cyc(LW, 1, ev(1, 1), "lw_d");
    cyc(LW, 1, ev(2, 1), "lw_a");  cyc(LW, 1, ev(3, 1), "lw_r");
    cyc(LW, 1, ev(4, 1), "lw_wb");

    // SW with three wait cycles in MEMWR
    cyc(SW, 1, ev(0, 1), "sw_f");  cyc(SW, 1, ev(1, 1), "sw_d");
    cyc(SW, 1, ev(2, 1), "sw_a");
    for (int i = 0; i < 3; i++) cyc(SW, 0, ev(5, 0), "sw_wait");
    cyc(SW, 1, ev(5, 1), "sw_done");

    // R-type, BEQ, J
    cyc(RT, 1, ev(0, 1), "r_f");   cyc(RT, 1, ev(1, 1), "r_d");
    cyc(RT, 1, ev(6, 1), "r_ex");  cyc(RT, 1, ev(7, 1), "r_wb");
    cyc(BQ, 1, ev(0, 1), "beq_f"); cyc(BQ, 1, ev(1, 1), "beq_d");
    cyc(BQ, 1, ev(8, 1), "beq_br");
    cyc(JJ, 1, ev(0, 1), "j_f");   cyc(JJ, 1, ev(1, 1), "j_d");
    cyc(JJ, 1, ev(9, 1), "j_j");

    // Illegal opcode
    cyc(BAD, 1, ev(0, 1), "ill_f"); cyc(BAD, 1, ev(1, 1, 1), "ill_d");

    // ADDI: legal only when the option is built in
    cyc(AD, 1, ev(0, 1), "addi_f");
`ifdef MULTICYCLE_ADDI_EN
    cyc(AD, 1, ev(1, 1), "addi_d"); cyc(AD, 1, ev(10, 1), "addi_ex");
    cyc(AD, 1, ev(11, 1), "addi_wb");
`else
    cyc(AD, 1, ev(1, 1, 1), "addi_ill");
`endif

    // FETCH timeout at the 16th wait cycle, then ready winning in the 16th cycle
    for (int i = 0; i < 16; i++) cyc(RT, 0, ev(0, 0, 0, (i == 15)), "f_to");
    for (int i = 0; i < 15; i++) cyc(RT, 0, ev(0, 0), "f_wait");
    cyc(RT, 1, ev(0, 1), "f_ready_win");
    cyc(RT, 1, ev(1, 1), "f_after_win");
    cyc(RT, 1, ev(6, 1), "r2_ex");  cyc(RT, 1, ev(7, 1), "r2_wb");

    // MEMRD timeout aborts LW without MEMWB
    cyc(LW, 1, ev(0, 1), "lwt_f");  cyc(LW, 1, ev(1, 1), "lwt_d");
    cyc(LW, 1, ev(2, 1), "lwt_a");
    for (int i = 0; i < 16; i++) cyc(LW, 0, ev(3, 0, 0, (i == 15)), "lwt_rd");
    cyc(LW, 0, ev(0, 0), "lwt_refetch");
    cyc(LW, 1, ev(0, 1), "lwt_f2");

    // Async reset during MEMWB
    cyc(LW, 1, ev(1, 1), "lwr_d");  cyc(LW, 1, ev(2, 1), "lwr_a");
    cyc(LW, 1, ev(3, 1), "lwr_r");
    chk("lwr_in_wb", obs, ev(4, 1));
    #2 rst_n = 1'b0;
    #1 chk("async_rst", obs, 22'd0);
    mem_ready = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_release", obs, ev(0, 0));
    cyc(JJ, 1, ev(0, 1), "post_f"); cyc(JJ, 1, ev(1, 1), "post_d");
    cyc(JJ, 1, ev(9, 1), "post_j");

    @(negedge clk);
    if (exp_q.size() != 0) chk("queue_drain", 22'(exp_q.size()), 22'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore FSM sequencing a multi-cycle MIPS datapath: shared memory, IR, A/B/ALUOut registers, one ALU.
- Executes R-type, LW, SW, BEQ and J over 3–5 states each, instead of decoding them in a single cycle.
- Adds a memory ready handshake with a wait-timeout, and flags illegal opcodes.
- Sits between the IR opcode field and the datapath mux/enable inputs; the ALU-control block consumes ALUOp.

Parameters:
- TIMEOUT, 16: max consecutive wait cycles in a memory state before abort.
- TO_W, 5: width of the wait counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  6  IR[31:26], valid from DECODE onward
- mem_ready  in  1  memory completes current read/write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU zero
- IorD  out  1  0=PC, 1=ALUOut addresses memory
- MemRead  out  1  memory read strobe, held until mem_ready
- MemWrite  out  1  memory write strobe, held until mem_ready
- IRWrite  out  1  IR load
- MemToReg  out  1  1=MDR, 0=ALUOut to register file
- RegDst  out  1  1=rd, 0=rt
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0=PC, 1=A
- ALUSrcB  out  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
- ALUOp  out  2  00=add, 01=sub, 10=funct
- PCSource  out  2  00=ALU, 01=ALUOut, 10=jump target
- illegal_op  out  1  one-cycle pulse on unknown opcode
- mem_err  out  1  one-cycle pulse on wait timeout
- state  out  4  current state, debug

Behaviour:
- Reset:
  - rst_n=0 forces state=FETCH(0) and wait counter=0 immediately.
  - All outputs are gated to 0 while rst_n=0, except state=0.
  - Reset mid-instruction abandons it; no partial PC or register write occurs after rst_n falls.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, ADDI_EX 10, ADDI_WB 11. Codes 12–15 go to FETCH next cycle with all outputs 0.
- Per-state outputs (any signal not listed is 0):
  - FETCH: MemRead=1, ALUSrcB=01. IRWrite=1 and PCWrite=1 only in the cycle mem_ready=1.
  - DECODE: ALUSrcB=11.
  - MEMADR: ALUSrcA=1, ALUSrcB=10.
  - MEMRD: MemRead=1, IorD=1.
  - MEMWB: RegWrite=1, MemToReg=1.
  - MEMWR: MemWrite=1, IorD=1.
  - EXEC: ALUSrcA=1, ALUOp=10.
  - RWB: RegWrite=1, RegDst=1.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01.
  - JUMP: PCWrite=1, PCSource=10.
  - ADDI_EX: ALUSrcA=1, ALUSrcB=10.
  - ADDI_WB: RegWrite=1.
- Transitions:
  - FETCH goes to DECODE when mem_ready=1.
  - DECODE decodes op: 000000→EXEC, 100011/101011→MEMADR, 000100→BRANCH, 000010→JUMP. Any other op pulses illegal_op and goes to FETCH.
  - MEMADR goes to MEMRD for LW and to MEMWR for SW.
  - MEMRD goes to MEMWB on mem_ready. MEMWR goes to FETCH on mem_ready.
  - MEMWB, RWB, BRANCH and JUMP go to FETCH. EXEC goes to RWB.
- Memory wait:
  - Applies in FETCH, MEMRD and MEMWR.
  - The counter increments each cycle mem_ready=0 and clears on state change.
  - When the counter equals TIMEOUT-1 with mem_ready=0: mem_err pulses and the FSM goes to FETCH with no PC, IR or register write.
  - A FETCH timeout restarts FETCH at the same PC.
  - mem_ready=1 in the timeout cycle wins: normal completion, no mem_err.
- Instruction latency with mem_ready always 1: LW 5 cycles, SW/R/ADDI 4, BEQ/J 3.

Optional Feature:
- Macro: MULTICYCLE_ADDI_EN.
- Defined: op 001000 (ADDI) goes DECODE→ADDI_EX→ADDI_WB→FETCH.
- Undefined: states 10 and 11 do not exist and are treated as illegal codes; op 001000 pulses illegal_op.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - the state enum/localparams;
  - ALUSrcB, ALUOp and PCSource encodings.
- One natural sub-module, ctrl_wait_timer: wait counter plus timeout compare, with inputs clk, rst_n, busy, ready and output expire.

Test Plan:
- LW, op=100011, mem_ready=1: states 0,1,2,3,4,0. MemToReg=1 and RegWrite=1 exactly in state 4.
- SW, mem_ready low for 3 cycles in MEMWR: MemWrite=1 and IorD=1 held for 4 cycles; FETCH follows with no mem_err.
- R-type then BEQ: RegDst=1 and RegWrite=1 in RWB; in BRANCH, PCWriteCond=1, PCSource=01, ALUOp=01; BEQ takes 3 cycles.
- op=111111 in DECODE: illegal_op=1 for one cycle; next state=0; no write strobes asserted.
- TIMEOUT=16, mem_ready held 0 in FETCH: mem_err pulses at cycle 16; PCWrite and IRWrite stay 0; FETCH is re-entered.
- rst_n dropped asynchronously during MEMWB: RegWrite falls without waiting for a clock edge; after release, state=0 on the first edge.
